// File: rtl/cube_led_encoder_if.sv
// rtl/cube_led_encoder_if.sv - serialised pixel bit handshake between raster controller and LED encoder
interface cube_led_encoder_if;
    logic bit_in;
    logic bit_last;
    logic bit_valid;
    logic bit_ready;

    modport master (output bit_in, output bit_last, output bit_valid, input bit_ready);
    modport slave  (input bit_in, input bit_last, input bit_valid, output bit_ready);
endinterface

// File: rtl/cube_led_encoder.sv
// rtl/cube_led_encoder.sv - one-wire LED symbol encoder fed through a one-entry bit buffer
// Optional macro CUBE_ENC_UNDERRUN_EN: starvation ends the frame and raises a sticky underrun flag.
module cube_led_encoder #(
    parameter int T_PERIOD = 30,
    parameter int T0H      = 9,
    parameter int T1H      = 17,
    parameter int T_LATCH  = 1200
) (
    input  logic              clk,
    input  logic              reset,
    cube_led_encoder_if.slave bit_if,
    input  logic              clear_underrun,
    output logic              led_out,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    typedef enum logic [1:0] {IDLE, SYM, LATCH} state_t;

    localparam logic [7:0]  PERIOD_LAST = 8'(T_PERIOD - 1);
    localparam logic [7:0]  HIGH0       = 8'(T0H);
    localparam logic [7:0]  HIGH1       = 8'(T1H);
    localparam logic [11:0] LATCH_LAST  = 12'(T_LATCH - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [11:0] lcnt, lcnt_next;
    logic        full, buf_bit, buf_last;
    logic        cur_bit, cur_last, cur_bit_next, cur_last_next;
    logic        accept, load, led_next, done_next;
`ifdef CUBE_ENC_UNDERRUN_EN
    logic        starve;
`endif

    assign bit_if.bit_ready = !full && !reset;
    assign accept           = bit_if.bit_valid && bit_if.bit_ready;
    assign busy             = (state != IDLE) || full;

    // Counters default to zero so every state entry starts them cleared.
    always_comb begin
        state_next    = state;
        cnt_next      = '0;
        lcnt_next     = '0;
        cur_bit_next  = cur_bit;
        cur_last_next = cur_last;
        load          = 1'b0;
        done_next     = 1'b0;
`ifdef CUBE_ENC_UNDERRUN_EN
        starve        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (full) begin
                    load       = 1'b1;
                    state_next = SYM;
                end
            end
            SYM: begin
                if (cnt == PERIOD_LAST) begin
                    if (cur_last) begin
                        state_next = LATCH;
                    end else if (full) begin
                        load = 1'b1;
                    end else begin
`ifdef CUBE_ENC_UNDERRUN_EN
                        starve     = 1'b1;
                        state_next = LATCH;
`else
                        state_next = IDLE;
`endif
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            LATCH: begin
                if (lcnt == LATCH_LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    lcnt_next = lcnt + 12'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            cur_bit_next  = buf_bit;
            cur_last_next = buf_last;
        end
        // The line is registered from next-state values so it stays aligned with cnt.
        led_next = (state_next == SYM) && (cnt_next < (cur_bit_next ? HIGH1 : HIGH0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lcnt       <= '0;
            full       <= 1'b0;
            buf_bit    <= 1'b0;
            buf_last   <= 1'b0;
            cur_bit    <= 1'b0;
            cur_last   <= 1'b0;
            led_out    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            lcnt       <= lcnt_next;
            cur_bit    <= cur_bit_next;
            cur_last   <= cur_last_next;
            led_out    <= led_next;
            frame_done <= done_next;
            if (accept) begin
                full     <= 1'b1;
                buf_bit  <= bit_if.bit_in;
                buf_last <= bit_if.bit_last;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

`ifdef CUBE_ENC_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = clear_underrun;
    assign underrun     = 1'b0;
`endif

endmodule

// File: tb/tb_cube_led_encoder.sv
// tb/tb_cube_led_encoder.sv - self-checking bench for cube_led_encoder
module tb_cube_led_encoder;
    localparam int T_PERIOD = 30;
    localparam int T0H      = 9;
    localparam int T1H      = 17;
    localparam int T_LATCH  = 1200;
    localparam int MAXC     = 65536;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear_underrun = 1'b0;
    logic led_out, busy, frame_done, underrun;

    cube_led_encoder_if bif();

    cube_led_encoder #(.T_PERIOD(T_PERIOD), .T0H(T0H), .T1H(T1H), .T_LATCH(T_LATCH)) dut (
        .clk(clk), .reset(reset), .bit_if(bif), .clear_underrun(clear_underrun),
        .led_out(led_out), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle record: index k holds the value seen in the cycle after edge k.
    logic led_tr[MAXC];
    logic done_tr[MAXC];
    logic busy_tr[MAXC];
    logic ready_tr[MAXC];
    logic ur_tr[MAXC];
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            led_tr[cyc]   = led_out;
            done_tr[cyc]  = frame_done;
            busy_tr[cyc]  = busy;
            ready_tr[cyc] = bif.bit_ready;
            ur_tr[cyc]    = underrun;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Upstream driver: MSB first, valid held high, optional stall before one bit.
    int acc_q[$];
    task automatic drive_frame(input logic [31:0] data, input int n, input int stall_at, input int stall_len);
        int budget;
        acc_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                bif.bit_valid = 1'b0;
                budget = 0;
                while (!bif.bit_ready && budget < 200) begin
                    tick();
                    budget++;
                end
                repeat (stall_len) tick();
            end
            bif.bit_in    = data[n - 1 - i];
            bif.bit_last  = (i == n - 1);
            bif.bit_valid = 1'b1;
            budget = 0;
            do begin
                tick();
                budget++;
            end while (!ready_tr[cyc - 1] && budget < 3000);
            if (!ready_tr[cyc - 1]) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: bit %0d not accepted within %0d cycles", i, budget);
            end
            acc_q.push_back(cyc);
        end
        bif.bit_valid = 1'b0;
        bif.bit_last  = 1'b0;
    endtask

    // Reference model: list of symbol start cycles with their bits, plus frame_done cycles.
    int   sym_s[$];
    logic sym_b[$];
    int   done_q[$];
    logic exp_ur;

    task automatic model_clear();
        sym_s.delete();
        sym_b.delete();
        done_q.delete();
    endtask

    task automatic model_contig(input logic [31:0] data, input int n, input int s0);
        for (int i = 0; i < n; i++) begin
            sym_s.push_back(s0 + i * T_PERIOD);
            sym_b.push_back(data[n - 1 - i]);
        end
        done_q.push_back(s0 + n * T_PERIOD + T_LATCH);
    endtask

    // A bit accepted at edge A can start no earlier than A+1 and no earlier than the end of the previous symbol.
    task automatic model_acc(input logic [31:0] data, input int n, input int floor_c);
        int s, prev_s, a, d;
        prev_s = 0;
        for (int i = 0; i < n; i++) begin
            a = acc_q[i];
            if (i == 0) begin
                s = max2(a + 1, floor_c);
            end else if (a + 1 <= prev_s + T_PERIOD) begin
                s = prev_s + T_PERIOD;
            end else begin
`ifdef CUBE_ENC_UNDERRUN_EN
                d = prev_s + T_PERIOD + T_LATCH;
                done_q.push_back(d);
                exp_ur = 1'b1;
                s = max2(a + 1, d + 1);
`else
                d = 0;
                s = a + 1;
`endif
            end
            sym_s.push_back(s);
            sym_b.push_back(data[n - 1 - i]);
            prev_s = s;
        end
        done_q.push_back(prev_s + T_PERIOD + T_LATCH);
    endtask

    function automatic logic exp_led(input int k);
        foreach (sym_s[j]) begin
            if (k >= sym_s[j] && k < sym_s[j] + (sym_b[j] ? T1H : T0H)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_done(input int k);
        foreach (done_q[j]) if (done_q[j] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_wave(input string name, input int w0, input int w1);
        int bad_led, bad_done;
        bad_led  = -1;
        bad_done = -1;
        for (int k = w0; k < w1; k++) begin
            if (led_tr[k] !== exp_led(k) && bad_led < 0) bad_led = k;
            if (done_tr[k] !== exp_done(k) && bad_done < 0) bad_done = k;
        end
        check({name, "_led_first_bad_cycle"}, bad_led, -1);
        check({name, "_done_first_bad_cycle"}, bad_done, -1);
    endtask

    typedef struct {
        logic b;
        int   high;
        int   low;
    } vec_t;

    initial begin
        #700000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int a, s, fh, h, l, k, d, last_done;
        logic [31:0] data;
        int n;

        tbl[0] = '{1'b1, 17, 1213};
        tbl[1] = '{1'b0, 9, 1221};
        tbl[2] = '{1'b0, 9, 1221};
        tbl[3] = '{1'b1, 17, 1213};
        exp_ur = 1'b0;

        bif.bit_in    = 1'b0;
        bif.bit_last  = 1'b0;
        bif.bit_valid = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_ready", bif.bit_ready, 0);
        check("reset_led", led_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_underrun", underrun, 0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", bif.bit_ready, 1);

        // Single-bit frames: latency, high width, low run until frame_done, busy fall.
        for (int t = 0; t < 4; t++) begin
            drive_frame({31'b0, tbl[t].b}, 1, -1, 0);
            a = acc_q[0];
            wait_until(a + T_PERIOD + T_LATCH + 8);
            fh = a;
            while (led_tr[fh] !== 1'b1 && fh < a + 10) fh++;
            check($sformatf("tbl%0d_latency", t), fh - a, 1);
            h = 0;
            k = fh;
            while (led_tr[k] === 1'b1 && h < 300) begin h++; k++; end
            check($sformatf("tbl%0d_high", t), h, tbl[t].high);
            l = 0;
            while (done_tr[k] !== 1'b1 && led_tr[k] === 1'b0 && l < 5000) begin l++; k++; end
            check($sformatf("tbl%0d_low_to_done", t), l, tbl[t].low);
            d = k;
            check($sformatf("tbl%0d_busy_at_done", t), busy_tr[d], 0);
            check($sformatf("tbl%0d_busy_before_done", t), busy_tr[d - 1], 1);
            check($sformatf("tbl%0d_done_single", t), done_tr[d + 1], 0);
            repeat (3) tick();
        end

        // 24 bits streamed back-to-back.
        drive_frame(32'h00A5C300, 24, -1, 0);
        model_clear();
        model_contig(32'h00A5C300, 24, acc_q[0] + 1);
        wait_until(done_q[0] + 5);
        check_wave("stream24", acc_q[0] - 2, done_q[0] + 4);

        // Randomised frames, valid held high.
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 8);
            data = $urandom;
            repeat ($urandom_range(1, 20)) tick();
            drive_frame(data, n, -1, 0);
            model_clear();
            model_contig(data, n, acc_q[0] + 1);
            wait_until(done_q[0] + 5);
            check_wave($sformatf("rand%0d", r), acc_q[0] - 2, done_q[0] + 4);
        end

        // Upstream withholds bit 3 for 50 cycles.
        data = 32'h2D;
        drive_frame(data, 6, 3, 50);
        model_clear();
        exp_ur = 1'b0;
        model_acc(data, 6, 0);
        last_done = done_q[done_q.size() - 1];
        wait_until(last_done + 5);
        check_wave("stall", acc_q[0] - 2, last_done + 4);
`ifdef CUBE_ENC_UNDERRUN_EN
        check("stall_underrun_before", ur_tr[sym_s[2] + T_PERIOD - 1], 0);
        check("stall_underrun_set", ur_tr[sym_s[2] + T_PERIOD], 1);
        check("stall_underrun_sticky", underrun, 1);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        tick();
        check("stall_underrun_cleared", underrun, 0);
`else
        check("stall_underrun_zero", underrun, 0);
        check("stall_gap_low", led_tr[sym_s[2] + T_PERIOD + 5], 0);
`endif

        // Next frame offered during the latch gap.
        tick();
        drive_frame(32'h1, 1, -1, 0);
        model_clear();
        model_contig(32'h1, 1, acc_q[0] + 1);
        s = acc_q[0] + 1;
        wait_until(s + T_PERIOD + 100);
        drive_frame(32'h0, 1, -1, 0);
        a = acc_q[0];
        check("latch_ready_drop", ready_tr[a], 0);
        model_acc(32'h0, 1, done_q[0] + 1);
        wait_until(done_q[1] + 5);
        check_wave("latch_offer", s - 2, done_q[1] + 4);
        check("latch_busy_at_done", busy_tr[done_q[0]], 1);
        check("latch_start_after_done", led_tr[done_q[0] + 1], 1);

        // Reset during the fifth cycle of a 1 symbol.
        tick();
        drive_frame(32'h1, 1, -1, 0);
        s = acc_q[0] + 1;
        wait_until(s + 4);
        reset = 1'b1;
        tick();
        check("midreset_led", led_out, 0);
        check("midreset_busy", busy, 0);
        check("midreset_ready", bif.bit_ready, 0);
        check("midreset_was_high", led_tr[s + 4], 1);
        reset = 1'b0;
        k = cyc;
        tick();
        drive_frame(32'h0, 1, -1, 0);
        model_clear();
        model_contig(32'h0, 1, acc_q[0] + 1);
        wait_until(done_q[0] + 5);
        check_wave("after_reset", k, done_q[0] + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
